// File: rtl/data_mem_responder.sv
// Data-memory responder: word storage answering load/store requests over a
// valid/ready request-response handshake after LATENCY wait cycles.
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
    localparam logic [3:0]  LAT_M1     = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          c_write;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [3:0]    c_be;
    logic          c_err;
    logic [AW-1:0] c_idx;

    // Commit operands: with zero latency RESP is entered on the accepting
    // edge itself, before the latches hold the request, so use the live inputs.
    always_comb begin
        accept     = 1'b0;
        enter_resp = 1'b0;
        c_write    = lat_write;
        c_addr     = lat_addr;
        c_wdata    = lat_wdata;
        c_be       = lat_be;
        if (state == ST_IDLE) begin
            c_write = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end
        accept = reset && (state == ST_IDLE) && req_valid && req_ready;
        if (reset) begin
            if (accept && (LATENCY == 0))
                enter_resp = 1'b1;
            if ((state == ST_WAIT) && (cnt == 4'd0))
                enter_resp = 1'b1;
        end
        c_err = (c_addr[1:0] != 2'b00) || (c_addr >= ADDR_LIMIT);
        c_idx = c_addr[AW+1:2];
    end

    // Storage: byte-enabled store commit on entry to RESP; never reset.
    always_ff @(posedge clk) begin
        if (enter_resp && c_write && !c_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (c_be[b])
                    mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
        end else begin
            if (enter_resp) begin
                state      <= ST_RESP;
                resp_valid <= 1'b1;
                resp_err   <= c_err;
                resp_rdata <= (!c_err && !c_write) ? mem[c_idx] : '0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        if (LATENCY > 0) begin
                            state <= ST_WAIT;
                            cnt   <= LAT_M1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
